// File: rtl/pipe_hazard_ctrl_if.sv
// Bus between the pipeline and the hazard controller.
// Carries the redirect sources, the hold requests, the IF handshake
// and the stall/flush/redirect results.
// The master side is the pipeline; the slave side is the controller.
interface pipe_hazard_ctrl_if #(
  parameter int XLEN         = 32,
  parameter int NUM_STAGES   = 5,
  parameter int NUM_HOLD_SRC = 3
);
  logic                    br_taken_i;
  logic [XLEN-1:0]         br_target_i;
  logic                    trap_req_i;
  logic [XLEN-1:0]         trap_target_i;
  logic [NUM_HOLD_SRC-1:0] hold_req_i;
  logic                    fetch_ready_i;
  logic                    redirect_valid_o;
  logic [XLEN-1:0]         redirect_pc_o;
  logic [NUM_STAGES-1:0]   stall_o;
  logic [NUM_STAGES-1:0]   flush_o;
  logic                    hold_flag_o;
  logic                    busy_o;

  modport master (
    output br_taken_i, br_target_i, trap_req_i, trap_target_i,
           hold_req_i, fetch_ready_i,
    input  redirect_valid_o, redirect_pc_o, stall_o, flush_o,
           hold_flag_o, busy_o
  );

  modport slave (
    input  br_taken_i, br_target_i, trap_req_i, trap_target_i,
           hold_req_i, fetch_ready_i,
    output redirect_valid_o, redirect_pc_o, stall_o, flush_o,
           hold_flag_o, busy_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the RV32I exception/interrupt pipeline.
// It arbitrates EX branch redirects, CLINT trap redirects and hold requests.
// A redirect that IF cannot take yet is latched until IF accepts it.
// After an accepted trap redirect, the front end is flushed for a few
// extra bubble cycles.
module pipe_hazard_ctrl #(
  parameter int XLEN         = 32,
  parameter int NUM_STAGES   = 5,
  parameter int EX_STAGE     = 2,
  parameter int NUM_HOLD_SRC = 3,
  parameter int TRAP_BUBBLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int CNT_W = (TRAP_BUBBLES > 0) ? $clog2(TRAP_BUBBLES + 1) : 1;

  // Stages in front of EX, stages up to and including EX, and the bubble
  // slot just behind EX.
  localparam logic [NUM_STAGES-1:0] FRONT_MASK =
    (NUM_STAGES'(1) << EX_STAGE) - NUM_STAGES'(1);
  localparam logic [NUM_STAGES-1:0] TRAP_MASK =
    (NUM_STAGES'(1) << (EX_STAGE + 1)) - NUM_STAGES'(1);
  localparam logic [NUM_STAGES-1:0] BUB_MASK =
    NUM_STAGES'(1) << (EX_STAGE + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
  logic              pend_is_trap_q, pend_is_trap_d;
  logic              busy_q, busy_d;

  logic                  redir_v;
  logic [XLEN-1:0]       redir_pc;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] flush;
  logic                  hold_any;
  logic                  eff_trap;

  assign hold_any = |bus.hold_req_i;

  // Next-state, redirect selection and stall/flush generation per state
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pend_pc_d      = pend_pc_q;
    pend_is_trap_d = pend_is_trap_q;
    redir_v        = 1'b0;
    redir_pc       = '0;
    stall          = '0;
    flush          = '0;
    eff_trap       = 1'b0;
    case (state_q)
      RUN, DRAIN: begin
        if (bus.trap_req_i) begin
          redir_v  = 1'b1;
          redir_pc = bus.trap_target_i;
          flush    = TRAP_MASK;
          if (!bus.fetch_ready_i) begin
            state_d        = PEND;
            pend_pc_d      = bus.trap_target_i;
            pend_is_trap_d = 1'b1;
            cnt_d          = '0;
          end else if (TRAP_BUBBLES > 0) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(TRAP_BUBBLES);
          end else begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end else if (state_q == DRAIN) begin
          flush = TRAP_MASK;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else if (bus.br_taken_i) begin
          redir_v  = 1'b1;
          redir_pc = bus.br_target_i;
          flush    = FRONT_MASK;
          if (!bus.fetch_ready_i) begin
            state_d        = PEND;
            pend_pc_d      = bus.br_target_i;
            pend_is_trap_d = 1'b0;
          end
        end else if (hold_any) begin
          stall = TRAP_MASK;
          flush = BUB_MASK;
        end
      end
      PEND: begin
        redir_v  = 1'b1;
        eff_trap = bus.trap_req_i | pend_is_trap_q;
        if (bus.trap_req_i) begin
          redir_pc       = bus.trap_target_i;
          pend_pc_d      = bus.trap_target_i;
          pend_is_trap_d = 1'b1;
        end else begin
          redir_pc = pend_pc_q;
        end
        flush = eff_trap ? TRAP_MASK : FRONT_MASK;
        if (bus.fetch_ready_i) begin
          pend_pc_d      = '0;
          pend_is_trap_d = 1'b0;
          if (eff_trap && (TRAP_BUBBLES > 0)) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(TRAP_BUBBLES);
          end else begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != RUN);
  end

  // State, drain counter, latched redirect and registered busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      pend_pc_q      <= '0;
      pend_is_trap_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_pc_q      <= pend_pc_d;
      pend_is_trap_q <= pend_is_trap_d;
      busy_q         <= busy_d;
    end
  end

  // Flush beats stall in the same stage; all outputs are quiet in reset.
  assign bus.redirect_valid_o = rst_n & redir_v;
  assign bus.redirect_pc_o    = rst_n ? redir_pc : '0;
  assign bus.stall_o          = rst_n ? (stall & ~flush) : '0;
  assign bus.flush_o          = rst_n ? flush : '0;
  assign bus.hold_flag_o      = rst_n & (hold_any | busy_q);
  assign bus.busy_o           = busy_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a scoreboard of expected
// outputs, pushed when a step is driven and popped when it is sampled.
module tb_pipe_hazard_ctrl;

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic [4:0]  st;
    logic [4:0]  fl;
    logic        hf;
    logic        bz;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   checks;
  int   errors;
  int   step;

  pipe_hazard_ctrl_if #(.XLEN(32), .NUM_STAGES(5), .NUM_HOLD_SRC(3)) bus ();

  pipe_hazard_ctrl #(
    .XLEN(32), .NUM_STAGES(5), .EX_STAGE(2), .NUM_HOLD_SRC(3), .TRAP_BUBBLES(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL step%0d.%s: observed %0h expected %0h", step, tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic rst, input logic br, input logic [31:0] bt,
    input logic tr, input logic [31:0] tt, input logic [2:0] hd, input logic rdy,
    input logic e_rv, input logic [31:0] e_pc, input logic [4:0] e_st,
    input logic [4:0] e_fl, input logic e_hf, input logic e_bz);
    exp_t e;
    rst_n             = rst;
    bus.br_taken_i    = br;
    bus.br_target_i   = bt;
    bus.trap_req_i    = tr;
    bus.trap_target_i = tt;
    bus.hold_req_i    = hd;
    bus.fetch_ready_i = rdy;
    e.rv = e_rv; e.pc = e_pc; e.st = e_st; e.fl = e_fl; e.hf = e_hf; e.bz = e_bz;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL step%0d.scoreboard: observed empty queue expected entry", step);
    end else begin
      e = sb.pop_front();
      checkField("redirect_valid", 32'(bus.redirect_valid_o), 32'(e.rv));
      checkField("redirect_pc",    bus.redirect_pc_o,         e.pc);
      checkField("stall",          32'(bus.stall_o),          32'(e.st));
      checkField("flush",          32'(bus.flush_o),          32'(e.fl));
      checkField("hold_flag",      32'(bus.hold_flag_o),      32'(e.hf));
      checkField("busy",           32'(bus.busy_o),           32'(e.bz));
    end
  endtask

  // One clock step: drive after the edge, sample at the falling edge.
  task automatic runStep(
    input logic rst, input logic br, input logic [31:0] bt,
    input logic tr, input logic [31:0] tt, input logic [2:0] hd, input logic rdy,
    input logic e_rv, input logic [31:0] e_pc, input logic [4:0] e_st,
    input logic [4:0] e_fl, input logic e_hf, input logic e_bz);
    applyStimulus(rst, br, bt, tr, tt, hd, rdy, e_rv, e_pc, e_st, e_fl, e_hf, e_bz);
    @(negedge clk);
    checkOutput();
    step++;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] BT  = 32'h0000_0100;
  localparam logic [31:0] BT2 = 32'h0000_0200;
  localparam logic [31:0] TT  = 32'h8000_0000;
  localparam logic [31:0] TT2 = 32'h8000_0040;

  initial begin
    checks = 0;
    errors = 0;
    step   = 0;
    //      rst br bt  tr tt   hold    rdy  rv pc   stall     flush     hf bz
    // reset with active requests: everything quiet
    runStep(0, 1, BT,  1, TT,  3'b111, 1,   0, 0,   5'b00000, 5'b00000, 0, 0);
    runStep(1, 0, 0,   0, 0,   3'b000, 1,   0, 0,   5'b00000, 5'b00000, 0, 0);
    // branch accepted immediately
    runStep(1, 1, BT,  0, 0,   3'b000, 1,   1, BT,  5'b00000, 5'b00011, 0, 0);
    runStep(1, 0, 0,   0, 0,   3'b000, 1,   0, 0,   5'b00000, 5'b00000, 0, 0);
    // branch with IF stalled for three cycles, new branch ignored in PEND
    runStep(1, 1, BT,  0, 0,   3'b000, 0,   1, BT,  5'b00000, 5'b00011, 0, 0);
    runStep(1, 1, BT2, 0, 0,   3'b000, 0,   1, BT,  5'b00000, 5'b00011, 1, 1);
    runStep(1, 0, 0,   0, 0,   3'b000, 0,   1, BT,  5'b00000, 5'b00011, 1, 1);
    runStep(1, 0, 0,   0, 0,   3'b000, 1,   1, BT,  5'b00000, 5'b00011, 1, 1);
    runStep(1, 0, 0,   0, 0,   3'b000, 1,   0, 0,   5'b00000, 5'b00000, 0, 0);
    // trap beats branch, then exactly two drain cycles
    runStep(1, 1, BT2, 1, TT,  3'b000, 1,   1, TT,  5'b00000, 5'b00111, 0, 0);
    runStep(1, 1, BT,  0, 0,   3'b001, 1,   0, 0,   5'b00000, 5'b00111, 1, 1);
    runStep(1, 0, 0,   0, 0,   3'b000, 1,   0, 0,   5'b00000, 5'b00111, 1, 1);
    runStep(1, 0, 0,   0, 0,   3'b000, 1,   0, 0,   5'b00000, 5'b00000, 0, 0);
    // hold alone, then hold overridden by a branch
    runStep(1, 0, 0,   0, 0,   3'b010, 1,   0, 0,   5'b00111, 5'b01000, 1, 0);
    runStep(1, 1, BT,  0, 0,   3'b010, 1,   1, BT,  5'b00000, 5'b00011, 1, 0);
    // trap arriving while a branch is pending
    runStep(1, 1, BT,  0, 0,   3'b000, 0,   1, BT,  5'b00000, 5'b00011, 0, 0);
    runStep(1, 0, 0,   1, TT,  3'b000, 0,   1, TT,  5'b00000, 5'b00111, 1, 1);
    runStep(1, 0, 0,   0, 0,   3'b000, 0,   1, TT,  5'b00000, 5'b00111, 1, 1);
    runStep(1, 0, 0,   0, 0,   3'b000, 1,   1, TT,  5'b00000, 5'b00111, 1, 1);
    runStep(1, 0, 0,   0, 0,   3'b000, 1,   0, 0,   5'b00000, 5'b00111, 1, 1);
    // new trap during drain reloads the counter
    runStep(1, 0, 0,   1, TT2, 3'b000, 1,   1, TT2, 5'b00000, 5'b00111, 1, 1);
    runStep(1, 0, 0,   0, 0,   3'b000, 1,   0, 0,   5'b00000, 5'b00111, 1, 1);
    runStep(1, 0, 0,   0, 0,   3'b000, 1,   0, 0,   5'b00000, 5'b00111, 1, 1);
    runStep(1, 0, 0,   0, 0,   3'b000, 1,   0, 0,   5'b00000, 5'b00000, 0, 0);
    // reset while a trap is pending discards it
    runStep(1, 0, 0,   1, TT,  3'b000, 0,   1, TT,  5'b00000, 5'b00111, 0, 0);
    runStep(0, 0, 0,   0, 0,   3'b000, 0,   0, 0,   5'b00000, 5'b00000, 0, 0);
    runStep(1, 0, 0,   0, 0,   3'b000, 0,   0, 0,   5'b00000, 5'b00000, 0, 0);
    runStep(1, 0, 0,   0, 0,   3'b100, 1,   0, 0,   5'b00111, 5'b01000, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control unit for the RV32I exception/interrupt pipeline.
- Arbitrates EX-stage branch redirects, CLINT trap redirects and N hold requests.
- Produces per-stage stall/flush vectors plus one PC redirect to IF.
- Unlike the previous passthrough controller, it latches a redirect until IF accepts it and inserts configurable post-trap drain bubbles.

Parameters:
XLEN, 32, PC/target width
NUM_STAGES, 5, pipeline stages; bit 0 = IF, increasing toward WB
EX_STAGE, 2, index of stage resolving branches; must satisfy EX_STAGE+1 < NUM_STAGES
NUM_HOLD_SRC, 3, number of independent hold requesters (e.g. CLINT, load-use, mul/div)
TRAP_BUBBLES, 2, extra front-end flush cycles after a trap redirect is accepted (0 allowed)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
br_taken_i  in  1  branch/jump taken, from EX
br_target_i  in  XLEN  branch target, from EX
trap_req_i  in  1  trap/interrupt entry request, from CLINT
trap_target_i  in  XLEN  trap vector (mtvec-derived), from CLINT
hold_req_i  in  NUM_HOLD_SRC  per-source hold requests
fetch_ready_i  in  1  IF accepts a redirect this cycle
redirect_valid_o  out  1  PC redirect to IF
redirect_pc_o  out  XLEN  redirect target
stall_o  out  NUM_STAGES  per-stage hold (register keeps value)
flush_o  out  NUM_STAGES  per-stage bubble insert
hold_flag_o  out  1  global hold indication to CSR/CLINT
busy_o  out  1  controller not in RUN

Behaviour:
- Reset: clk and rst_n only; asynchronous, active-low. While rst_n=0: state=RUN, drain counter=0, pend_pc=0, pend_is_trap=0, and every output forced 0.
- States: RUN, PEND (redirect latched, waiting for IF), DRAIN (post-trap bubbles).
- FRONT mask = stages 0..EX_STAGE-1. TRAPMASK = stages 0..EX_STAGE. BUB = stage EX_STAGE+1.
- RUN, redirect:
  - redirect_valid_o = trap_req_i | br_taken_i, combinational (zero latency).
  - redirect_pc_o = trap_target_i if trap_req_i, else br_target_i. Trap wins over a simultaneous branch.
  - Branch flushes FRONT; trap flushes TRAPMASK.
- RUN, next state:
  - Redirect with fetch_ready_i=0: latch pc and pend_is_trap; next=PEND.
  - Trap with fetch_ready_i=1: next=DRAIN with counter=TRAP_BUBBLES, or RUN if TRAP_BUBBLES=0.
  - Branch with fetch_ready_i=1: stay RUN.
- RUN, hold: any hold_req_i bit with no redirect sets stall_o for stages 0..EX_STAGE and flush_o[BUB]=1. Redirect takes priority over hold that cycle: no stall, flush as above.
- PEND:
  - redirect_valid_o=1, redirect_pc_o=pend_pc (stable until accepted).
  - Flush FRONT, or TRAPMASK if pend_is_trap, every cycle.
  - br_taken_i ignored.
  - trap_req_i overwrites pend_pc, sets pend_is_trap and outputs trap_target_i combinationally that cycle.
  - Exit on fetch_ready_i=1: to DRAIN if pend_is_trap and TRAP_BUBBLES>0, else RUN.
- DRAIN:
  - flush_o=TRAPMASK for exactly TRAP_BUBBLES cycles; counter decrements each cycle; RUN after the cycle with counter=1.
  - br_taken_i ignored; hold_req_i only affects hold_flag_o.
  - trap_req_i is handled exactly as in RUN (new redirect, counter reload).
- Stall/flush rule: where flush_o and stall_o would both be 1 in a stage, flush wins and stall is cleared.
- Flags: hold_flag_o = |hold_req_i | busy_o. busy_o = (state != RUN), registered.
- Reset during PEND/DRAIN: immediately RUN, pending redirect discarded.

Test Plan:
- Reset: rst_n=0 with br_taken_i=1 and hold_req_i=3'b111 -> all outputs 0; release -> state RUN, busy_o=0.
- Branch, IF ready: br_taken_i=1, br_target_i=0x0000_0100, fetch_ready_i=1 -> same cycle redirect_valid_o=1, redirect_pc_o=0x100, flush_o=5'b00011; next cycle all clear.
- Branch, IF stalled: fetch_ready_i=0 for 3 cycles -> redirect_pc_o held at 0x100 and flush_o=5'b00011 each cycle, busy_o=1; after fetch_ready_i=1 -> RUN.
- Trap vs branch: trap_req_i and br_taken_i together, trap_target_i=0x8000_0000, TRAP_BUBBLES=2 -> redirect_pc_o=0x8000_0000, flush_o=5'b00111 on redirect cycle plus exactly 2 drain cycles, then RUN.
- Hold: hold_req_i=3'b010, no redirect -> stall_o=5'b00111, flush_o=5'b01000, hold_flag_o=1. Add br_taken_i -> stall_o=0, flush_o=5'b00011.
- Trap during PEND: branch pending at 0x100, then trap_req_i with 0x8000_0000 -> redirect_pc_o switches to 0x8000_0000, flush widens to 5'b00111; accept -> DRAIN.
